// File: rtl/sec_tick_timer.sv
// Minutes:seconds BCD up/down timer stepped by rising edges of the 1 Hz divider output.
// Optional lap-display hold is enabled with `define TIMER_LAP_EN.
module sec_tick_timer #(
   parameter int MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_src,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       load,
   input  logic       dir,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
`ifdef TIMER_LAP_EN
   input  logic       lap,
   output logic       lap_active,
`endif
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done,
   output logic       tick_pulse
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   localparam logic [7:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
   localparam logic [7:0] MAX_BIN = 8'(MAX_MIN);

   state_t     state_reg;
   logic [7:0] min_reg, sec_reg;
   logic       tick_d, dir_q;

   logic       tick_rise, tick_go, at_max, at_zero, up_hits, dn_hits, hit_end, load_ok;
   logic [7:0] up_min, up_sec, dn_min, dn_sec, nx_min, nx_sec, lmin_bin;

   // Two-digit BCD step; tens_lim is the tens digit at which the field wraps.
   function automatic logic [7:0] bcd_inc(input logic [7:0] d, input logic [3:0] tens_lim);
      if (d[3:0] != 4'd9)
         return {d[7:4], d[3:0] + 4'd1};
      else if (d[7:4] != tens_lim)
         return {d[7:4] + 4'd1, 4'd0};
      else
         return 8'h00;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] d, input logic [3:0] tens_lim);
      if (d[3:0] != 4'd0)
         return {d[7:4], d[3:0] - 4'd1};
      else if (d[7:4] != 4'd0)
         return {d[7:4] - 4'd1, 4'd9};
      else
         return {tens_lim, 4'd9};
   endfunction

   always_comb begin
      tick_rise = tick_src & ~tick_d;
      tick_go   = (state_reg == S_RUN) & ~stop & tick_rise;
      at_max    = (min_reg == MAX_BCD) && (sec_reg == 8'h59);
      at_zero   = (min_reg == 8'h00) && (sec_reg == 8'h00);
      // Both directions saturate at their end point rather than wrapping.
      up_sec    = at_max ? sec_reg : bcd_inc(sec_reg, 4'd5);
      up_min    = (!at_max && sec_reg == 8'h59) ? bcd_inc(min_reg, 4'd9) : min_reg;
      up_hits   = (up_min == MAX_BCD) && (up_sec == 8'h59);
      dn_sec    = at_zero ? sec_reg : bcd_dec(sec_reg, 4'd5);
      dn_min    = (!at_zero && sec_reg == 8'h00) ? bcd_dec(min_reg, 4'd9) : min_reg;
      dn_hits   = (dn_min == 8'h00) && (dn_sec == 8'h00);
      nx_min    = dir_q ? dn_min : up_min;
      nx_sec    = dir_q ? dn_sec : up_sec;
      hit_end   = dir_q ? dn_hits : up_hits;
      lmin_bin  = {4'd0, load_min[7:4]} * 8'd10 + {4'd0, load_min[3:0]};
      load_ok   = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                  (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9) &&
                  (lmin_bin <= MAX_BIN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         min_reg    <= 8'h00;
         sec_reg    <= 8'h00;
         tick_d     <= 1'b1;
         dir_q      <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b0;
         tick_pulse <= 1'b0;
      end else begin
         tick_d     <= tick_src;
         tick_pulse <= 1'b0;
         if (clear) begin
            state_reg <= S_IDLE;
            min_reg   <= 8'h00;
            sec_reg   <= 8'h00;
            dir_q     <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if (!stop && start) begin
                     dir_q <= dir;
                     if (dir && at_zero) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                     end else begin
                        state_reg <= S_RUN;
                        running   <= 1'b1;
                     end
                  end else if (!stop && load && load_ok) begin
                     min_reg <= load_min;
                     sec_reg <= load_sec;
                  end
               end
               S_RUN: begin
                  if (stop) begin
                     state_reg <= S_PAUSE;
                     running   <= 1'b0;
                  end else if (tick_rise) begin
                     tick_pulse <= 1'b1;
                     min_reg    <= nx_min;
                     sec_reg    <= nx_sec;
                     if (hit_end) begin
                        state_reg <= S_DONE;
                        running   <= 1'b0;
                        done      <= 1'b1;
                     end
                  end
               end
               S_PAUSE: begin
                  if (!stop && start) begin
                     state_reg <= S_RUN;
                     running   <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

`ifdef TIMER_LAP_EN
   logic [7:0] snap_min, snap_sec;
   logic       enter_done;

   assign enter_done = ~clear & tick_go & hit_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lap_active <= 1'b0;
         snap_min   <= 8'h00;
         snap_sec   <= 8'h00;
      end else if (clear || enter_done) begin
         lap_active <= 1'b0;
      end else if (state_reg == S_RUN && lap) begin
         lap_active <= ~lap_active;
         if (!lap_active) begin
            snap_min <= min_reg;
            snap_sec <= sec_reg;
         end
      end
   end

   // Snapshot and live count are both registers, so the mux adds no input-to-output path.
   assign min_bcd = lap_active ? snap_min : min_reg;
   assign sec_bcd = lap_active ? snap_sec : sec_reg;
`else
   logic unused_go;
   assign unused_go = tick_go;
   assign min_bcd   = min_reg;
   assign sec_bcd   = sec_reg;
`endif

endmodule

// File: tb/tb_sec_tick_timer.sv
// Bench for sec_tick_timer: directed scenarios plus random traffic against a seconds-count model.
// Exercises the lap feature when compiled with TIMER_LAP_EN.
module tb_sec_tick_timer;

   logic       clk, reset, tick_src, start, stop, clear, load, dir;
   logic [7:0] load_min, load_sec;
   logic [7:0] min0, sec0, min1, sec1;
   logic       run0, done0, tp0, run1, done1, tp1;
`ifdef TIMER_LAP_EN
   logic       lap, la0, la1;
`endif

   int errors = 0;
   int checks = 0;

   sec_tick_timer #(.MAX_MIN(59)) dut0 (
      .clk(clk), .reset(reset), .tick_src(tick_src), .start(start), .stop(stop),
      .clear(clear), .load(load), .dir(dir), .load_min(load_min), .load_sec(load_sec),
`ifdef TIMER_LAP_EN
      .lap(lap), .lap_active(la0),
`endif
      .min_bcd(min0), .sec_bcd(sec0), .running(run0), .done(done0), .tick_pulse(tp0));

   sec_tick_timer #(.MAX_MIN(1)) dut1 (
      .clk(clk), .reset(reset), .tick_src(tick_src), .start(start), .stop(stop),
      .clear(clear), .load(load), .dir(dir), .load_min(load_min), .load_sec(load_sec),
`ifdef TIMER_LAP_EN
      .lap(lap), .lap_active(la1),
`endif
      .min_bcd(min1), .sec_bcd(sec1), .running(run1), .done(done1), .tick_pulse(tp1));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Reference model: count kept as total seconds; st 0=idle 1=run 2=pause 3=done.
   typedef struct {
      int st;
      int total;
      bit dirq;
      bit tickd;
      bit tp;
      bit lap_act;
      int snap;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t mreset();
      mdl_t r;
      r.st = 0; r.total = 0; r.dirq = 0; r.tickd = 1; r.tp = 0; r.lap_act = 0; r.snap = 0;
      return r;
   endfunction

   function automatic int bcd_val(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit load_valid(input int maxm);
      return (load_min[7:4] <= 9) && (load_min[3:0] <= 9) && (load_sec[7:4] <= 5) &&
             (load_sec[3:0] <= 9) && (bcd_val(load_min) <= maxm);
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input int maxm);
      mdl_t n = m;
      int   maxt = maxm * 60 + 59;
      bit   rise;
      rise    = tick_src && !m.tickd;
      n.tickd = tick_src;
      n.tp    = 0;
      if (clear) begin
         n.st = 0; n.total = 0; n.dirq = 0; n.lap_act = 0;
         return n;
      end
      case (m.st)
         0: begin
            if (!stop && start) begin
               n.dirq = dir;
               n.st   = (dir && m.total == 0) ? 3 : 1;
            end else if (!stop && load && load_valid(maxm)) begin
               n.total = bcd_val(load_min) * 60 + bcd_val(load_sec);
            end
         end
         1: begin
            if (stop) n.st = 2;
            else if (rise) begin
               n.tp = 1;
               if (!m.dirq) begin
                  n.total = (m.total + 1 > maxt) ? maxt : m.total + 1;
                  if (n.total == maxt) n.st = 3;
               end else begin
                  n.total = (m.total > 0) ? m.total - 1 : 0;
                  if (n.total == 0) n.st = 3;
               end
            end
`ifdef TIMER_LAP_EN
            if (lap) begin
               if (!m.lap_act) n.snap = m.total;
               n.lap_act = !m.lap_act;
            end
            if (n.st == 3) n.lap_act = 0;
`endif
         end
         2: if (!stop && start) n.st = 1;
         default: ;
      endcase
      return n;
   endfunction

   function automatic logic [15:0] tobcd(input int t);
      int mm, ss;
      mm = t / 60;
      ss = t % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [18:0] mexp(input mdl_t m);
      logic [15:0] d;
      d = tobcd(m.lap_act ? m.snap : m.total);
      return {d, m.st == 1, m.st == 3, m.tp};
   endfunction

   task automatic step();
      @(posedge clk);
      if (reset) begin
         m0 = mstep(m0, 59);
         m1 = mstep(m1, 1);
      end
      #1;
      start = 0; stop = 0; clear = 0; load = 0;
`ifdef TIMER_LAP_EN
      lap = 0;
`endif
   endtask

   task automatic pulse_tick();
      tick_src = 1; step();
      tick_src = 0; step();
   endtask

   task automatic test_reset();
      reset = 0; tick_src = 1; start = 0; stop = 0; clear = 0; load = 0; dir = 0;
      load_min = 0; load_sec = 0;
`ifdef TIMER_LAP_EN
      lap = 0;
`endif
      m0 = mreset(); m1 = mreset();
      repeat (3) step();
      reset = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if ({min0, sec0, run0, done0, tp0} !== 19'd0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, {min0, sec0, run0, done0, tp0});
         end
      end
      tick_src = 0; step();
   endtask

   task automatic test_count_up();
      start = 1; dir = 0; step();
      checks++;
      if (run0 !== 1'b1) begin errors++; $display("FAIL up_start running got=%b exp=1", run0); end
      for (int i = 1; i <= 61; i++) begin
         tick_src = 1; step();
         checks++;
         if ({min0, sec0, tp0} !== {tobcd(i), 1'b1}) begin
            errors++;
            $display("FAIL up_edge n=%0d got=%h/%b exp=%h/1", i, {min0, sec0}, tp0, tobcd(i));
         end
         if (i == 60) begin
            checks++;
            if ({min0, sec0} !== 16'h0100) begin
               errors++; $display("FAIL up_carry got=%h exp=0100", {min0, sec0});
            end
         end
         tick_src = 0; step();
         checks++;
         if (tp0 !== 1'b0) begin errors++; $display("FAIL up_pulse_width n=%0d got=%b exp=0", i, tp0); end
      end
      checks++;
      if ({min0, sec0} !== 16'h0101) begin errors++; $display("FAIL up_final got=%h exp=0101", {min0, sec0}); end
      clear = 1; step();
   endtask

   task automatic test_count_down();
      load = 1; load_min = 8'h02; load_sec = 8'h00; step();
      checks++;
      if ({min0, sec0} !== 16'h0200) begin errors++; $display("FAIL dn_load got=%h exp=0200", {min0, sec0}); end
      start = 1; dir = 1; step();
      pulse_tick();
      checks++;
      if ({min0, sec0} !== 16'h0159) begin errors++; $display("FAIL dn_borrow got=%h exp=0159", {min0, sec0}); end
      repeat (119) pulse_tick();
      checks++;
      if ({min0, sec0, run0, done0} !== {16'h0000, 1'b0, 1'b1}) begin
         errors++; $display("FAIL dn_zero got=%h run=%b done=%b exp=0000/0/1", {min0, sec0}, run0, done0);
      end
      tick_src = 1; step();
      checks++;
      if ({min0, sec0, tp0} !== {16'h0000, 1'b0}) begin
         errors++; $display("FAIL dn_after_done got=%h tp=%b exp=0000/0", {min0, sec0}, tp0);
      end
      tick_src = 0; clear = 1; step();
      dir = 0;
   endtask

   task automatic test_saturate();
      load = 1; load_min = 8'h01; load_sec = 8'h58; step();
      start = 1; dir = 0; step();
      pulse_tick(); pulse_tick();
      checks++;
      if ({min1, sec1, run1, done1} !== {16'h0159, 1'b0, 1'b1}) begin
         errors++; $display("FAIL sat_reach got=%h run=%b done=%b exp=0159/0/1", {min1, sec1}, run1, done1);
      end
      checks++;
      if ({min0, sec0, run0, done0, tp0} !== mexp(m0)) begin
         errors++; $display("FAIL sat_wide got=%h exp=%h", {min0, sec0, run0, done0, tp0}, mexp(m0));
      end
      for (int i = 0; i < 3; i++) begin
         tick_src = 1; step();
         checks++;
         if ({min1, sec1, tp1} !== {16'h0159, 1'b0}) begin
            errors++; $display("FAIL sat_hold n=%0d got=%h tp=%b exp=0159/0", i, {min1, sec1}, tp1);
         end
         tick_src = 0; step();
      end
      start = 1; step();
      checks++;
      if ({run1, done1} !== 2'b01) begin errors++; $display("FAIL sat_start_ignored got=%b exp=01", {run1, done1}); end
      clear = 1; step();
      checks++;
      if ({min1, sec1, run1, done1} !== 18'd0) begin
         errors++; $display("FAIL sat_clear got=%h exp=0", {min1, sec1, run1, done1});
      end
   endtask

   task automatic test_stop_tick();
      start = 1; dir = 0; step();
      repeat (10) pulse_tick();
      checks++;
      if ({min0, sec0} !== 16'h0010) begin errors++; $display("FAIL st_pre got=%h exp=0010", {min0, sec0}); end
      stop = 1; tick_src = 1; step();
      checks++;
      if ({min0, sec0, run0, tp0} !== {16'h0010, 1'b0, 1'b0}) begin
         errors++; $display("FAIL st_discard got=%h run=%b tp=%b exp=0010/0/0", {min0, sec0}, run0, tp0);
      end
      tick_src = 0; step();
      repeat (5) pulse_tick();
      checks++;
      if ({min0, sec0} !== 16'h0010) begin errors++; $display("FAIL st_frozen got=%h exp=0010", {min0, sec0}); end
      start = 1; step();
      pulse_tick();
      checks++;
      if ({min0, sec0, run0} !== {16'h0011, 1'b1}) begin
         errors++; $display("FAIL st_resume got=%h run=%b exp=0011/1", {min0, sec0}, run0);
      end
      clear = 1; step();
   endtask

   task automatic test_bad_load();
      logic [7:0] mins [4] = '{8'h03, 8'h03, 8'h60, 8'h1A};
      logic [7:0] secs [4] = '{8'h25, 8'h60, 8'h00, 8'h00};
      for (int i = 0; i < 4; i++) begin
         load = 1; load_min = mins[i]; load_sec = secs[i]; step();
         checks++;
         if ({min0, sec0} !== 16'h0325) begin
            errors++; $display("FAIL load n=%0d got=%h exp=0325", i, {min0, sec0});
         end
         checks++;
         if ({min1, sec1, run1, done1, tp1} !== mexp(m1)) begin
            errors++; $display("FAIL load_max1 n=%0d got=%h exp=%h", i, {min1, sec1, run1, done1, tp1}, mexp(m1));
         end
      end
      clear = 1; step();
   endtask

   task automatic test_reset_mid();
      start = 1; dir = 0; step();
      repeat (3) pulse_tick();
      @(negedge clk);
      reset = 0;
      m0 = mreset(); m1 = mreset();
      #1;
      checks++;
      if ({min0, sec0, run0, done0, tp0} !== 19'd0) begin
         errors++; $display("FAIL reset_async got=%h exp=0", {min0, sec0, run0, done0, tp0});
      end
      step();
      reset = 1;
      pulse_tick();
      checks++;
      if ({min0, sec0, run0} !== 17'd0) begin
         errors++; $display("FAIL reset_no_resume got=%h exp=0", {min0, sec0, run0});
      end
   endtask

`ifdef TIMER_LAP_EN
   task automatic test_lap();
      start = 1; dir = 0; step();
      repeat (5) pulse_tick();
      lap = 1; step();
      checks++;
      if ({min0, sec0, la0} !== {16'h0005, 1'b1}) begin
         errors++; $display("FAIL lap_on got=%h la=%b exp=0005/1", {min0, sec0}, la0);
      end
      repeat (3) pulse_tick();
      checks++;
      if ({min0, sec0} !== 16'h0005) begin errors++; $display("FAIL lap_hold got=%h exp=0005", {min0, sec0}); end
      lap = 1; step();
      checks++;
      if ({min0, sec0, la0} !== {16'h0008, 1'b0}) begin
         errors++; $display("FAIL lap_off got=%h la=%b exp=0008/0", {min0, sec0}, la0);
      end
      clear = 1; step();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 2) == 0) tick_src = ~tick_src;
         start = ($urandom_range(0, 99) < 6);
         stop  = ($urandom_range(0, 99) < 3);
         clear = ($urandom_range(0, 99) < 1);
         load  = ($urandom_range(0, 99) < 5);
         dir   = 1'($urandom_range(0, 1));
`ifdef TIMER_LAP_EN
         lap   = ($urandom_range(0, 99) < 4);
`endif
         if ($urandom_range(0, 1) == 0) begin
            load_min = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            load_sec = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
         end else begin
            load_min = 8'($urandom_range(0, 255));
            load_sec = 8'($urandom_range(0, 255));
         end
         step();
         checks++;
         if ({min0, sec0, run0, done0, tp0} !== mexp(m0)) begin
            errors++; $display("FAIL rand0 cyc=%0d got=%h exp=%h", c, {min0, sec0, run0, done0, tp0}, mexp(m0));
         end
         checks++;
         if ({min1, sec1, run1, done1, tp1} !== mexp(m1)) begin
            errors++; $display("FAIL rand1 cyc=%0d got=%h exp=%h", c, {min1, sec1, run1, done1, tp1}, mexp(m1));
         end
`ifdef TIMER_LAP_EN
         checks++;
         if ({la0, la1} !== {m0.lap_act, m1.lap_act}) begin
            errors++; $display("FAIL rand_lap cyc=%0d got=%b exp=%b", c, {la0, la1}, {m0.lap_act, m1.lap_act});
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_saturate();
      test_stop_tick();
      test_bad_load();
`ifdef TIMER_LAP_EN
      test_lap();
`endif
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
